// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the CDB arbiter and its per-source FIFOs.
package cdb_arbiter_pkg;

   localparam int CDB_DEPTH = 4;
   localparam int NICK_W    = 5;
   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 32;

   typedef enum logic {
      SRC_EX  = 1'b0,
      SRC_SLB = 1'b1
   } cdb_src_e;

   typedef struct packed {
      logic [NICK_W-1:0] nick;
      logic [DATA_W-1:0] dt;
      logic              ac;
      logic [ADDR_W-1:0] j_pc;
   } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// Single-source result FIFO: push/pop/flush, head peek, count, full and empty.
// The count is the only source of full/empty; head/tail wrap modulo DEPTH.
module cdb_arbiter_fifo
   import cdb_arbiter_pkg::*;
#(
   parameter int DEPTH = CDB_DEPTH,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic             push,
   input  cdb_entry_t       din,
   input  logic             pop,
   output cdb_entry_t       head,
   output logic [PTR_W:0]   count,
   output logic             full,
   output logic             empty
);

   cdb_entry_t       mem_r [DEPTH];
   logic [PTR_W-1:0] head_r;
   logic [PTR_W-1:0] tail_r;
   logic [PTR_W:0]   count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full      = (count_r == (PTR_W+1)'(DEPTH));
   assign empty     = (count_r == (PTR_W+1)'(0));
   assign count     = count_r;
   assign head      = mem_r[head_r];
   // A push into a full FIFO is dropped even if a pop happens on the same edge.
   assign push_ok_s = push && !full;
   assign pop_ok_s  = pop && !empty;

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else if (en) begin
         if (flush) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
         end else begin
            if (push_ok_s) begin
               tail_r <= tail_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
               head_r <= head_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
               2'b10:   count_r <= count_r + (PTR_W+1)'(1);
               2'b01:   count_r <= count_r - (PTR_W+1)'(1);
               default: count_r <= count_r;
            endcase
         end
      end
   end

   // Entry storage; contents are don't-care while the slot is unoccupied.
   always_ff @(posedge clk) begin
      if (en && !flush && push_ok_s) begin
         mem_r[tail_r] <= din;
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Arbitrates EX and SLB results onto the registered common data bus.
// Define CDB_SLB_PRIO_EN for fixed SLB priority instead of round-robin.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int DEPTH = CDB_DEPTH,
   parameter int PTR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              iROB_clr,
   input  logic              iEX_en,
   input  logic [NICK_W-1:0] iEX_nick,
   input  logic [DATA_W-1:0] iEX_dt,
   input  logic              iEX_ac,
   input  logic [ADDR_W-1:0] iEX_j_pc,
   output logic              oEX_full,
   input  logic              iSLB_en,
   input  logic [NICK_W-1:0] iSLB_nick,
   input  logic [DATA_W-1:0] iSLB_dt,
   output logic              oSLB_full,
   output logic              oCDB_en,
   output logic [NICK_W-1:0] oCDB_nick,
   output logic [DATA_W-1:0] oCDB_dt,
   output logic              oCDB_ac,
   output logic [ADDR_W-1:0] oCDB_j_pc,
   output logic              oCDB_src,
   output logic              oERR
);

   cdb_entry_t     ex_in_s, slb_in_s, ex_head_s, slb_head_s, win_s;
   logic           ex_empty_s, ex_full_s, slb_empty_s, slb_full_s;
   logic [PTR_W:0] ex_count_s, slb_count_s;
   logic           ex_cand_s, slb_cand_s;
   logic           grant_ex_s, grant_slb_s, grant_s;
   logic           ex_push_s, ex_pop_s, slb_push_s, slb_pop_s;
   logic           active_s;
   cdb_entry_t     cdb_r;
   cdb_src_e       cdb_src_r;
   logic           cdb_en_r;
   logic           err_r;

   assign ex_in_s  = '{nick: iEX_nick, dt: iEX_dt, ac: iEX_ac, j_pc: iEX_j_pc};
   assign slb_in_s = '{nick: iSLB_nick, dt: iSLB_dt, ac: 1'b0, j_pc: 32'd0};
   assign active_s = rdy && !iROB_clr;

`ifndef CDB_SLB_PRIO_EN
   // Source that wins the next conflict; it points away from the last winner.
   cdb_src_e rr_ptr_r;

   // Round-robin pointer, moved only when something is granted.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_r <= SRC_EX;
      end else if (active_s && grant_s) begin
         rr_ptr_r <= grant_ex_s ? SRC_SLB : SRC_EX;
      end
   end
`endif

   // Candidate selection, grant decision and bypass/queue steering.
   always_comb begin
      grant_ex_s  = 1'b0;
      grant_slb_s = 1'b0;
      ex_cand_s   = !ex_empty_s || iEX_en;
      slb_cand_s  = !slb_empty_s || iSLB_en;
      if (ex_cand_s && slb_cand_s) begin
`ifdef CDB_SLB_PRIO_EN
         grant_slb_s = 1'b1;
`else
         if (rr_ptr_r == SRC_EX) begin
            grant_ex_s = 1'b1;
         end else begin
            grant_slb_s = 1'b1;
         end
`endif
      end else if (ex_cand_s) begin
         grant_ex_s = 1'b1;
      end else if (slb_cand_s) begin
         grant_slb_s = 1'b1;
      end else begin
         grant_ex_s  = 1'b0;
         grant_slb_s = 1'b0;
      end
      grant_s = grant_ex_s || grant_slb_s;

      if (grant_slb_s) begin
         win_s = slb_empty_s ? slb_in_s : slb_head_s;
      end else begin
         win_s = ex_empty_s ? ex_in_s : ex_head_s;
      end

      // A granted result from an empty FIFO goes straight to the bus.
      ex_pop_s   = grant_ex_s && !ex_empty_s;
      slb_pop_s  = grant_slb_s && !slb_empty_s;
      ex_push_s  = iEX_en && !(grant_ex_s && ex_empty_s);
      slb_push_s = iSLB_en && !(grant_slb_s && slb_empty_s);
   end

   cdb_arbiter_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo_ex (
      .clk   (clk),
      .rst   (rst),
      .en    (rdy),
      .flush (iROB_clr),
      .push  (ex_push_s),
      .din   (ex_in_s),
      .pop   (ex_pop_s),
      .head  (ex_head_s),
      .count (ex_count_s),
      .full  (ex_full_s),
      .empty (ex_empty_s)
   );

   cdb_arbiter_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo_slb (
      .clk   (clk),
      .rst   (rst),
      .en    (rdy),
      .flush (iROB_clr),
      .push  (slb_push_s),
      .din   (slb_in_s),
      .pop   (slb_pop_s),
      .head  (slb_head_s),
      .count (slb_count_s),
      .full  (slb_full_s),
      .empty (slb_empty_s)
   );

   // Registered CDB; data fields hold when nothing is granted.
   always_ff @(posedge clk) begin
      if (rst) begin
         cdb_en_r  <= 1'b0;
         cdb_r     <= '0;
         cdb_src_r <= SRC_EX;
      end else if (rdy) begin
         if (iROB_clr) begin
            cdb_en_r <= 1'b0;
         end else if (grant_s) begin
            cdb_en_r  <= 1'b1;
            cdb_r     <= win_s;
            cdb_src_r <= grant_slb_s ? SRC_SLB : SRC_EX;
         end else begin
            cdb_en_r <= 1'b0;
         end
      end
   end

   // Sticky overflow: a push attempted into a full FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_r <= 1'b0;
      end else if (active_s && ((ex_push_s && ex_full_s) || (slb_push_s && slb_full_s))) begin
         err_r <= 1'b1;
      end
   end

   assign oEX_full  = (ex_count_s >= (PTR_W+1)'(DEPTH-1));
   assign oSLB_full = (slb_count_s >= (PTR_W+1)'(DEPTH-1));
   assign oCDB_en   = cdb_en_r;
   assign oCDB_nick = cdb_r.nick;
   assign oCDB_dt   = cdb_r.dt;
   assign oCDB_ac   = cdb_r.ac;
   assign oCDB_j_pc = cdb_r.j_pc;
   assign oCDB_src  = cdb_src_r;
   assign oERR      = err_r;

endmodule
